// File: rtl/adder8_stream_pkg.sv
// rtl/adder8_stream_pkg.sv - shared types for the adder8 streaming stage
package adder8_stream_pkg;

    // Occupancy of the two-entry result buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // One buffered result: carry-out plus wrapped 8-bit sum
    typedef struct packed {
        logic       carry;
        logic [7:0] sum;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '{carry: 1'b0, sum: 8'h00};

    // Build a buffer entry from the operand and the adder's truncated sum;
    // the wrapped sum is smaller than an operand exactly when bit 8 was lost.
    function automatic entry_t make_entry(input logic [7:0] a, input logic [7:0] sum);
        entry_t e;
        e.sum   = sum;
        e.carry = (sum < a);
        return e;
    endfunction

endpackage

// File: rtl/adder8.sv
// rtl/adder8.sv - combinational 8-bit wrapping adder
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);

    // Plain modulo-256 addition; carry is reconstructed by the caller
    always_comb begin
        sum = a + b;
    end

endmodule

// File: rtl/adder8_stream.sv
// rtl/adder8_stream.sv - valid/ready adder stage with 2-entry skid buffer and pop counter
module adder8_stream
    import adder8_stream_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] count
);

    state_e           state_q, state_d;
    entry_t           head_q, head_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [7:0] add_sum;
    entry_t     new_entry;
    logic       push;
    logic       pop;

    adder8 u_adder8 (
        .a   (in_a),
        .b   (in_b),
        .sum (add_sum)
    );

    // Result entry for the operands currently offered
    always_comb begin
        new_entry = make_entry(in_a, add_sum);
    end

    // Handshake flags decode from the registered state only
    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = (state_q != FULL);
        out_sum   = head_q.sum;
        out_carry = head_q.carry;
        count     = count_q;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Next occupancy state
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:  if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Buffer steering: head feeds the output, skid catches a result while head stalls
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        case (state_q)
            EMPTY: if (push) head_d = new_entry;
            ONE: begin
                if (push && pop)  head_d = new_entry;
                else if (push)    skid_d = new_entry;
            end
            FULL:  if (pop) head_d = skid_q;
            default: begin
                head_d = ENTRY_ZERO;
                skid_d = ENTRY_ZERO;
            end
        endcase
    end

    // Completed-transaction counter, wraps naturally at 2^CNT_W
    always_comb begin
        count_d = count_q;
        if (pop) count_d = count_q + CNT_W'(1);
    end

    // State, buffer and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= ENTRY_ZERO;
            skid_q  <= ENTRY_ZERO;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/adder8_stream.md
# adder8_stream

Handshaked pipeline stage that wraps the team's combinational 8-bit adder (`adder8`) for streaming use. It accepts operand pairs over a valid/ready interface, computes the 8-bit wrapping sum plus a carry flag, and buffers results in a 2-entry skid buffer. It sits between an operand producer and any result consumer that can apply backpressure. It sustains one result per cycle with no bubbles.

## Interface
- `CNT_W`, default 16: width of the completed-transaction counter.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand pair on `in_a`/`in_b` is valid.
- `in_ready` output 1: stage can accept an operand pair this cycle.
- `in_a` input 8: operand A, unsigned.
- `in_b` input 8: operand B, unsigned.
- `out_valid` output 1: `out_sum`/`out_carry` hold a valid result.
- `out_ready` input 1: consumer accepts the result this cycle.
- `out_sum` output 8: (a + b) mod 256.
- `out_carry` output 1: carry-out of a + b (bit 8 of the 9-bit sum).
- `count` output CNT_W: number of results popped since reset, modulo 2^CNT_W.

## Operation
- **Push**: `in_valid && in_ready` at a rising edge. **Pop**: `out_valid && out_ready` at a rising edge.
- On push, the sum comes from the `adder8` instance. Carry = (sum < a), unsigned compare, which equals bit 8 of the 9-bit sum. The entry {carry, sum} is registered.
- Storage is two entries:
  - `head` drives `out_sum`/`out_carry`.
  - `skid` holds the second result when `head` is stalled.
- State machine, states EMPTY, ONE, FULL:
  - EMPTY, push → ONE; entry written to `head`.
  - ONE, push and no pop → FULL; entry written to `skid`.
  - ONE, pop and no push → EMPTY.
  - ONE, push and pop together → ONE; new entry written to `head`.
  - FULL, pop → ONE; `skid` moves to `head`.
  - FULL, no pop → FULL. A push cannot occur because `in_ready` is 0.
- `out_valid` = (state != EMPTY). `in_ready` = (state != FULL). Both decode directly from the state register, with no combinational path from `in_valid` or `out_ready`.
- `out_sum` and `out_carry` stay stable while `out_valid && !out_ready`.
- `count` increments by 1 on every pop and wraps to 0 from 2^CNT_W − 1.
- Results leave in acceptance order. There is no loss or duplication.
- Arithmetic: all values are unsigned. The sum truncates to 8 bits, and the overflow is reported only via `out_carry`.

## Timing
- Latency: an operand pair pushed at edge N is presented with `out_valid`=1 immediately after edge N, so it can pop at edge N+1.
- Throughput: 1 push and 1 pop per cycle in steady state with `out_ready`=1.
- Backpressure: the second push while `head` is stalled fills `skid`. `in_ready` drops to 0 after that edge and returns to 1 after the next pop.
- Reset values while `rst_n` is low take effect immediately (asynchronous):
  - state EMPTY
  - `out_valid` 0, `in_ready` 1
  - `out_sum` 0x00, `out_carry` 0
  - `count` 0
  - `head` and `skid` cleared
- Inputs are ignored while `rst_n` is low.
- Reset mid-operation discards all buffered results. The first push after `rst_n` rises is the first result out.

## Structure
- Shared package `adder8_stream_pkg` contains:
  - `state_e` enum {EMPTY, ONE, FULL}.
  - `entry_t` packed struct {logic carry; logic [7:0] sum}.
- The sub-module is one `adder8` instance on the input operands. There is no other hierarchy; the FSM, buffer and counter live in the top module.

## Test plan
- **Basic**: reset; push a=0x12, b=0x34 with `out_ready`=1 → next cycle `out_valid`=1, `out_sum`=0x46, `out_carry`=0; `count`=1 after the pop.
- **Wrap/carry**: push 0xFF+0x01 → sum 0x00, carry 1. Push 0x80+0x80 → sum 0x00, carry 1. Push 0x7F+0x80 → sum 0xFF, carry 0.
- **Backpressure**: hold `out_ready`=0 and offer 1+1, 2+2, 3+3 back-to-back.
  - The first two are accepted; `in_ready`=0 after the second edge; the third is held.
  - Raise `out_ready` → outputs 0x02, 0x04, 0x06 in order; `count`=3.
- **Full rate**: 1000 random pairs with `in_valid`=1; `out_ready` randomly toggled → every output matches the reference model in order; `out_sum` stays stable during stalls.
- **Counter wrap** (`CNT_W`=4 for this test): 17 pops → `count`=1.
- **Async reset mid-op**: reach FULL, then drop `rst_n` between edges.
  - Immediately: `out_valid`=0, `in_ready`=1, `count`=0.
  - After release, push 0x05+0x06 → first output 0x0B.
